// File: rtl/mod_instr_encoder.sv
// Program loader. It packs symbolic MIPS commands into 32-bit words and writes them one at a time into imem.
// Optional feature: define ENC_CHECKSUM_EN to add a running XOR checksum of acked words.
module mod_instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic [ADDR_W:0]   word_count,
    output logic              full,
    output logic              error
`ifdef ENC_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    typedef enum logic {IDLE, WRITE} state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LAST = (ADDR_W+1)'(DEPTH - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W:0]   count_q;
    logic              full_q;
    logic              error_q;
    logic [31:0]       wdata_d;
    logic              kindLegal;

    always_comb begin
        wdata_d   = '0;
        kindLegal = 1'b1;
        case (in_kind)
            4'd0:    wdata_d = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h20};
            4'd1:    wdata_d = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h22};
            4'd2:    wdata_d = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h24};
            4'd3:    wdata_d = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h25};
            4'd4:    wdata_d = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h2A};
            4'd5:    wdata_d = {6'h23, in_rs, in_rt, in_imm};
            4'd6:    wdata_d = {6'h2B, in_rs, in_rt, in_imm};
            4'd7:    wdata_d = {6'h04, in_rs, in_rt, in_imm};
            4'd8:    wdata_d = {6'h02, in_target};
            default: kindLegal = 1'b0;
        endcase
    end

    // The pointer saturates on the filling ack so imem_addr never leaves the DEPTH window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            wdata_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            error_q <= 1'b0;
        end else if (clear) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            wdata_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && !full_q) begin
                        if (kindLegal) begin
                            wdata_q <= wdata_d;
                            state_q <= WRITE;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (imem_ack) begin
                        count_q <= count_q + 1'b1;
                        state_q <= IDLE;
                        if (count_q == LAST) begin
                            full_q <= 1'b1;
                        end else begin
                            ptr_q <= ptr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ENC_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else if (clear) begin
            checksum_q <= '0;
        end else if (state_q == WRITE && imem_ack) begin
            checksum_q <= checksum_q ^ wdata_q;
        end
    end

    assign checksum = checksum_q;
`endif

    assign in_ready   = (state_q == IDLE) && !full_q;
    assign imem_we    = (state_q == WRITE);
    assign imem_addr  = BASE + ptr_q;
    assign imem_wdata = wdata_q;
    assign word_count = count_q;
    assign full       = full_q;
    assign error      = error_q;

endmodule

// File: tb/tb_mod_instr_encoder.sv
// Directed bench for mod_instr_encoder (DEPTH=4): encoding table, ack latency, full/clear, illegal kinds and reset.
// Checksum checks are compiled in when ENC_CHECKSUM_EN is defined.
module tb_mod_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ack;
    logic [8:0]  word_count;
    logic        full;
    logic        error;
`ifdef ENC_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int total = 0;
    int bad   = 0;

    mod_instr_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_rs      (in_rs),
        .in_rt      (in_rt),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_target  (in_target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ack   (imem_ack),
        .word_count (word_count),
        .full       (full),
        .error      (error)
`ifdef ENC_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  kind;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] target;
        logic        legal;
        logic [31:0] expWord;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents one command for a single cycle; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] target);
        @(negedge clk);
        in_kind   = kind;
        in_rs     = rs;
        in_rt     = rt;
        in_rd     = rd;
        in_imm    = imm;
        in_target = target;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic ackNow();
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    task automatic pulseClear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"add",    4'd0,  5'd1,  5'd2,  5'd3,  16'hBEEF, 26'h3FFFFFF, 1'b1, 32'h00221820};
        vecs[1]  = '{"sub",    4'd1,  5'd4,  5'd5,  5'd6,  16'hFFFF, 26'h1234567, 1'b1, 32'h00853022};
        vecs[2]  = '{"and",    4'd2,  5'd7,  5'd8,  5'd9,  16'h0001, 26'h0000001, 1'b1, 32'h00E84824};
        vecs[3]  = '{"or",     4'd3,  5'd31, 5'd31, 5'd31, 16'hAAAA, 26'h2AAAAAA, 1'b1, 32'h03FFF825};
        vecs[4]  = '{"slt",    4'd4,  5'd10, 5'd11, 5'd12, 16'h5555, 26'h1555555, 1'b1, 32'h014B602A};
        vecs[5]  = '{"lw",     4'd5,  5'd29, 5'd8,  5'd31, 16'h0004, 26'h3FFFFFF, 1'b1, 32'h8FA80004};
        vecs[6]  = '{"sw",     4'd6,  5'd3,  5'd4,  5'd17, 16'h1234, 26'h2222222, 1'b1, 32'hAC641234};
        vecs[7]  = '{"beq",    4'd7,  5'd1,  5'd2,  5'd30, 16'hFFFF, 26'h3333333, 1'b1, 32'h1022FFFF};
        vecs[8]  = '{"j",      4'd8,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000010, 1'b1, 32'h08000010};
        vecs[9]  = '{"jmax",   4'd8,  5'd5,  5'd6,  5'd7,  16'h1111, 26'h3FFFFFF, 1'b1, 32'h0BFFFFFF};
        vecs[10] = '{"ill9",   4'd9,  5'd1,  5'd2,  5'd3,  16'h0004, 26'h0000010, 1'b0, 32'h00000000};
        vecs[11] = '{"ill15",  4'd15, 5'd1,  5'd2,  5'd3,  16'h0004, 26'h0000010, 1'b0, 32'h00000000};

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; imem_ack = 1'b0;
        in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
        #12;
        checkOutput("rst_we",    {31'd0, imem_we}, 32'd0);
        checkOutput("rst_addr",  {24'd0, imem_addr}, 32'd0);
        checkOutput("rst_wdata", imem_wdata, 32'd0);
        checkOutput("rst_count", {23'd0, word_count}, 32'd0);
        checkOutput("rst_full",  {31'd0, full}, 32'd0);
        checkOutput("rst_error", {31'd0, error}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Every kind once, from a cleared loader, with an immediate ack.
        for (int i = 0; i < 12; i++) begin
            pulseClear();
            applyStimulus(vecs[i].kind, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].target);
            if (vecs[i].legal) begin
                checkOutput({vecs[i].name, "_we"},    {31'd0, imem_we}, 32'd1);
                checkOutput({vecs[i].name, "_addr"},  {24'd0, imem_addr}, 32'd0);
                checkOutput({vecs[i].name, "_wdata"}, imem_wdata, vecs[i].expWord);
                ackNow();
                checkOutput({vecs[i].name, "_weoff"}, {31'd0, imem_we}, 32'd0);
                checkOutput({vecs[i].name, "_count"}, {23'd0, word_count}, 32'd1);
                checkOutput({vecs[i].name, "_err"},   {31'd0, error}, 32'd0);
            end else begin
                checkOutput({vecs[i].name, "_we"},    {31'd0, imem_we}, 32'd0);
                checkOutput({vecs[i].name, "_err"},   {31'd0, error}, 32'd1);
                checkOutput({vecs[i].name, "_count"}, {23'd0, word_count}, 32'd0);
                checkOutput({vecs[i].name, "_rdy"},   {31'd0, in_ready}, 32'd1);
            end
        end

        // LW with a 3-cycle ack delay while a J waits on in_valid, then the J lands at addr 1.
        pulseClear();
        applyStimulus(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
        in_kind = 4'd8; in_target = 26'h0000010; in_rs = 5'd3; in_imm = 16'h7777; in_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checkOutput($sformatf("lwhold%0d_we", c),    {31'd0, imem_we}, 32'd1);
            checkOutput($sformatf("lwhold%0d_wdata", c), imem_wdata, 32'h8FA80004);
            checkOutput($sformatf("lwhold%0d_addr", c),  {24'd0, imem_addr}, 32'd0);
            checkOutput($sformatf("lwhold%0d_rdy", c),   {31'd0, in_ready}, 32'd0);
            if (c < 3) @(negedge clk);
        end
        ackNow();
        checkOutput("lwdone_count", {23'd0, word_count}, 32'd1);
        checkOutput("lwdone_addr",  {24'd0, imem_addr}, 32'd1);
        checkOutput("lwdone_rdy",   {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("j_we",    {31'd0, imem_we}, 32'd1);
        checkOutput("j_wdata", imem_wdata, 32'h08000010);
        checkOutput("j_addr",  {24'd0, imem_addr}, 32'd1);
        ackNow();
        checkOutput("j_count", {23'd0, word_count}, 32'd2);
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        checkOutput("idleack_count", {23'd0, word_count}, 32'd2);

        // Illegal kind is sticky across a following legal write.
        applyStimulus(4'd12, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        checkOutput("ill12_err",   {31'd0, error}, 32'd1);
        checkOutput("ill12_we",    {31'd0, imem_we}, 32'd0);
        checkOutput("ill12_count", {23'd0, word_count}, 32'd2);
        applyStimulus(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0);
        checkOutput("beq_wdata", imem_wdata, 32'h1022FFFF);
        checkOutput("beq_addr",  {24'd0, imem_addr}, 32'd2);
        ackNow();
        checkOutput("sticky_err", {31'd0, error}, 32'd1);

        // Fill all four words, then hold in_valid against a full loader.
        pulseClear();
        for (int w = 0; w < 4; w++) begin
            applyStimulus(4'd0, 5'(w), 5'd2, 5'd3, 16'h0, 26'h0);
            checkOutput($sformatf("fill%0d_addr", w), {24'd0, imem_addr}, 32'(w));
            ackNow();
        end
        checkOutput("full_flag",  {31'd0, full}, 32'd1);
        checkOutput("full_rdy",   {31'd0, in_ready}, 32'd0);
        checkOutput("full_count", {23'd0, word_count}, 32'd4);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("full_hold_we",    {31'd0, imem_we}, 32'd0);
        checkOutput("full_hold_count", {23'd0, word_count}, 32'd4);
        checkOutput("full_addr_bound", {31'd0, (imem_addr <= 8'd3)}, 32'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checkOutput("clr_full",  {31'd0, full}, 32'd0);
        checkOutput("clr_count", {23'd0, word_count}, 32'd0);
        checkOutput("clr_we",    {31'd0, imem_we}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("refill_we",   {31'd0, imem_we}, 32'd1);
        checkOutput("refill_addr", {24'd0, imem_addr}, 32'd0);
        ackNow();

        // clear wins over a same-cycle ack.
        pulseClear();
        applyStimulus(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        clear = 1'b1; imem_ack = 1'b1;
        @(negedge clk);
        clear = 1'b0; imem_ack = 1'b0;
        checkOutput("clrack_count", {23'd0, word_count}, 32'd0);
        checkOutput("clrack_we",    {31'd0, imem_we}, 32'd0);
        checkOutput("clrack_addr",  {24'd0, imem_addr}, 32'd0);

        // Reset mid-WRITE drops imem_we without waiting for a clock edge.
        applyStimulus(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0);
        checkOutput("prerst_we", {31'd0, imem_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncrst_we",    {31'd0, imem_we}, 32'd0);
        checkOutput("asyncrst_wdata", imem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("postrst_count", {23'd0, word_count}, 32'd0);

`ifdef ENC_CHECKSUM_EN
        pulseClear();
        applyStimulus(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
        ackNow();
        checkOutput("cks_one", checksum, 32'h00221820);
        applyStimulus(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0);
        ackNow();
        checkOutput("cks_two", checksum, 32'h8F8A1824);
        applyStimulus(4'd8, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
        clear = 1'b1; imem_ack = 1'b1;
        @(negedge clk);
        clear = 1'b0; imem_ack = 1'b0;
        checkOutput("cks_clear", checksum, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
